// File: rtl/move_scheduler.sv
// Purpose: paces player movement on the grid, one clamped step per tick, offered over valid/ready.
// Latency: WAIT lasts TICK_DIV cycles, then MOVE for 1 cycle, then ISSUE for at least 1 cycle (TICK_DIV+2 per step with ready high).
// Backpressure: ISSUE holds step_valid, pos, dir_q and hit_wall until step_ready; the tick counter is frozen while stalled.
module move_scheduler #(
  parameter int          GRID_W   = 16,
  parameter int          GRID_H   = 12,
  parameter int          XW       = 4,
  parameter int          YW       = 4,
  parameter logic [23:0] TICK_DIV = 24'd5000000,
  parameter int          START_X  = 0,
  parameter int          START_Y  = 0
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic [2:0]    directions,
  input  logic          run,
  input  logic          restart,
  input  logic          step_ready,
  output logic          step_valid,
  output logic [XW-1:0] pos_x,
  output logic [YW-1:0] pos_y,
  output logic [2:0]    dir_q,
  output logic          hit_wall,
  output logic [7:0]    step_count
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_MOVE, S_ISSUE} state_t;

  // Sums carry two extra bits: one for the sign and one so that
  // (GRID_W-1)+1 cannot alias a negative value when GRID_W == 2**XW.
  localparam logic [XW+1:0] X_MAX   = (XW+2)'(GRID_W - 1);
  localparam logic [YW+1:0] Y_MAX   = (YW+2)'(GRID_H - 1);
  localparam logic [XW+1:0] X_POS   = (XW+2)'(1);
  localparam logic [XW+1:0] X_NEG   = '1;
  localparam logic [YW+1:0] Y_POS   = (YW+2)'(1);
  localparam logic [YW+1:0] Y_NEG   = '1;
  localparam logic [XW-1:0] X_START = XW'(START_X);
  localparam logic [YW-1:0] Y_START = YW'(START_Y);
  localparam logic [23:0]   TICK_LAST = TICK_DIV - 24'd1;
  localparam logic [2:0]    DIR_RIGHT = 3'd6;

  state_t        state_q, state_d;
  logic [23:0]   cnt_q, cnt_d;
  logic [XW-1:0] pos_x_q, pos_x_d;
  logic [YW-1:0] pos_y_q, pos_y_d;
  logic [2:0]    dir_lat_q, dir_lat_d;
  logic          hit_q, hit_d;
  logic [7:0]    count_q, count_d;

  logic [XW+1:0] dx, x_sum;
  logic [YW+1:0] dy, y_sum;
  logic [XW-1:0] x_new;
  logic [YW-1:0] y_new;
  logic          x_clip, y_clip;

  // Decode the keypad direction code into per-axis unit steps (y grows downward).
  always_comb begin
    dx = '0;
    dy = '0;
    case (directions)
      3'd0:    begin dx = X_NEG; dy = Y_POS; end
      3'd1:    begin dx = X_NEG;             end
      3'd2:    begin dx = X_NEG; dy = Y_NEG; end
      3'd3:    begin             dy = Y_POS; end
      3'd4:    begin             dy = Y_NEG; end
      3'd5:    begin dx = X_POS; dy = Y_POS; end
      3'd6:    begin dx = X_POS;             end
      default: begin dx = X_POS; dy = Y_NEG; end
    endcase
  end

  // Candidate position with each axis clamped independently to the grid.
  always_comb begin
    x_sum  = {2'b00, pos_x_q} + dx;
    y_sum  = {2'b00, pos_y_q} + dy;
    x_new  = x_sum[XW-1:0];
    y_new  = y_sum[YW-1:0];
    x_clip = 1'b0;
    y_clip = 1'b0;
    if (x_sum[XW+1]) begin
      x_new  = '0;
      x_clip = 1'b1;
    end else if (x_sum > X_MAX) begin
      x_new  = X_MAX[XW-1:0];
      x_clip = 1'b1;
    end
    if (y_sum[YW+1]) begin
      y_new  = '0;
      y_clip = 1'b1;
    end else if (y_sum > Y_MAX) begin
      y_new  = Y_MAX[YW-1:0];
      y_clip = 1'b1;
    end
  end

  // Next-state logic: restart beats run=0, which beats the normal step sequence.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pos_x_d   = pos_x_q;
    pos_y_d   = pos_y_q;
    dir_lat_d = dir_lat_q;
    hit_d     = hit_q;
    count_d   = count_q;
    if (restart) begin
      pos_x_d = X_START;
      pos_y_d = Y_START;
      cnt_d   = '0;
      count_d = '0;
      hit_d   = 1'b0;
      state_d = run ? S_WAIT : S_IDLE;
    end else if (!run) begin
      // A pending step is withdrawn but the position it produced stays.
      state_d = S_IDLE;
      cnt_d   = '0;
      hit_d   = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end
        S_WAIT: begin
          if (cnt_q == TICK_LAST) begin
            cnt_d   = '0;
            state_d = S_MOVE;
          end else begin
            cnt_d = cnt_q + 24'd1;
          end
        end
        S_MOVE: begin
          dir_lat_d = directions;
          pos_x_d   = x_new;
          pos_y_d   = y_new;
          hit_d     = x_clip | y_clip;
          state_d   = S_ISSUE;
        end
        S_ISSUE: begin
          if (step_ready) begin
            count_d = count_q + 8'd1;
            hit_d   = 1'b0;
            state_d = S_WAIT;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      pos_x_q   <= X_START;
      pos_y_q   <= Y_START;
      dir_lat_q <= DIR_RIGHT;
      hit_q     <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pos_x_q   <= pos_x_d;
      pos_y_q   <= pos_y_d;
      dir_lat_q <= dir_lat_d;
      hit_q     <= hit_d;
      count_q   <= count_d;
    end
  end

  assign step_valid = (state_q == S_ISSUE);
  assign pos_x      = pos_x_q;
  assign pos_y      = pos_y_q;
  assign dir_q      = dir_lat_q;
  assign hit_wall   = hit_q;
  assign step_count = count_q;

endmodule
